ram_req_ctrl_2p: RTL

Requester/initiator side of the CPU's 16x128 two-port RAM. It accepts instruction-fetch requests on a read-only channel (RAM port 0) and load/store requests on a read/write channel (RAM port 1). It drives the RAM enable, address and data pins, absorbs the RAM's one-cycle registered read latency, and returns responses with valid pulses. It also detects same-address fetch-vs-store collisions and delays the fetch so that it returns the newly written data.

---
 rtl/ram_req_ctrl_2p.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/ram_req_ctrl_2p.sv
// Requester side of a 16x128 two-port RAM: read-only fetch channel on port 0 and
// load/store channel on port 1, each a 3-state FSM, with fetch-after-store hazard stall.
module ram_req_ctrl_2p #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16,
    parameter int HCNT_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_rvalid,
    output logic [DATA_W-1:0] fetch_rdata,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic              mem_ready,
    output logic              mem_rvalid,
    output logic              mem_wack,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [HCNT_W-1:0] hazard_cnt,
    output logic              ram_read_en0,
    output logic              ram_write_en0,
    output logic [ADDR_W-1:0] ram_addr0,
    output logic [DATA_W-1:0] ram_din0,
    input  logic [DATA_W-1:0] ram_dout0,
    output logic              ram_read_en1,
    output logic              ram_write_en1,
    output logic [ADDR_W-1:0] ram_addr1,
    output logic [DATA_W-1:0] ram_din1,
    input  logic [DATA_W-1:0] ram_dout1
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t            f_state, d_state;
    logic [ADDR_W-1:0] f_addr, d_addr;
    logic              d_we;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] f_rdata_q, m_rdata_q;
    logic              f_rvalid_q, m_rvalid_q, m_wack_q;
    logic [HCNT_W-1:0] hcnt_q;
    logic              hazard;

    // Fetch of an address being stored this cycle must wait one cycle to see new data
    assign hazard = (f_state == ISSUE) && (d_state == ISSUE) && d_we && (d_addr == f_addr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_state    <= IDLE;
            f_addr     <= '0;
            f_rdata_q  <= '0;
            f_rvalid_q <= 1'b0;
            hcnt_q     <= '0;
        end else begin
            f_rvalid_q <= 1'b0;
            case (f_state)
                IDLE: begin
                    if (fetch_req) begin
                        f_addr  <= fetch_addr;
                        f_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (hazard) begin
                        if (hcnt_q != '1)
                            hcnt_q <= hcnt_q + HCNT_W'(1);
                    end else begin
                        f_rvalid_q <= 1'b1;
                        f_state    <= DONE;
                    end
                end
                DONE: begin
                    f_rdata_q <= ram_dout0;
                    f_state   <= IDLE;
                end
                default: f_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_state    <= IDLE;
            d_addr     <= '0;
            d_we       <= 1'b0;
            d_wdata    <= '0;
            m_rdata_q  <= '0;
            m_rvalid_q <= 1'b0;
            m_wack_q   <= 1'b0;
        end else begin
            m_rvalid_q <= 1'b0;
            m_wack_q   <= 1'b0;
            case (d_state)
                IDLE: begin
                    if (mem_req) begin
                        d_addr  <= mem_addr;
                        d_we    <= mem_we;
                        d_wdata <= mem_wdata;
                        d_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_rvalid_q <= ~d_we;
                    m_wack_q   <= d_we;
                    d_state    <= DONE;
                end
                DONE: begin
                    if (!d_we)
                        m_rdata_q <= ram_dout1;
                    d_state <= IDLE;
                end
                default: d_state <= IDLE;
            endcase
        end
    end

    assign fetch_ready  = (f_state == IDLE);
    assign fetch_rvalid = f_rvalid_q;
    assign fetch_rdata  = (f_state == DONE) ? ram_dout0 : f_rdata_q;

    assign mem_ready    = (d_state == IDLE);
    assign mem_rvalid   = m_rvalid_q;
    assign mem_wack     = m_wack_q;
    assign mem_rdata    = (d_state == DONE && !d_we) ? ram_dout1 : m_rdata_q;

    assign hazard_cnt   = hcnt_q;

    assign ram_read_en0  = (f_state == ISSUE) && !hazard;
    assign ram_write_en0 = 1'b0;
    assign ram_addr0     = f_addr;
    assign ram_din0      = '0;

    assign ram_read_en1  = (d_state == ISSUE) && !d_we;
    assign ram_write_en1 = (d_state == ISSUE) && d_we;
    assign ram_addr1     = d_addr;
    assign ram_din1      = d_wdata;

endmodule
